// File: rtl/irq_timer_bank_if.sv
// Register-bus interface for irq_timer_bank.
// Signal names are given from the timer bank's point of view:
//   req_i    single-cycle access strobe
//   we_i     1 = write, 0 = read
//   addr_i   word address {channel, reg[1:0]}
//   wdata_i  write data
//   rdata_o  read data, valid with ack_o, held until the next read ack
//   ack_o    access complete, one cycle after req_i
// The CPU side uses the master modport; the timer bank uses the slave modport.
interface irq_timer_bank_if #(
    parameter int ADDR_W = 4
);
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              ack_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ack_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ack_o
    );
endinterface

// File: rtl/irq_timer_bank.sv
// Bank of N_CH independent programmable interrupt timers for picorv32.
// Each channel has CTRL (EN, ONESHOT, IE), PERIOD, COUNT (read-only) and a
// write-one-to-clear STATUS (PENDING, OVERRUN). A channel fires every PERIOD
// cycles while enabled and drives a registered level IRQ on bit IRQ_BASE+c.
// Ports:
//   clk      clock
//   rst      synchronous active-low reset
//   bus      register bus (slave side), see irq_timer_bank_if
//   eoi_i    picorv32 end-of-interrupt; bit IRQ_BASE+c clears channel c pending
//   irq_o    level interrupts, bits outside the bank tied to 0
module irq_timer_bank #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 32,
    parameter int IRQ_BASE = 4
) (
    input  logic               clk,
    input  logic               rst,
    irq_timer_bank_if.slave    bus,
    input  logic [31:0]        eoi_i,
    output logic [31:0]        irq_o
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CH_W-1:0]  ch_s;
    logic [1:0]       reg_s;

    logic [2:0]       ctrl_q   [N_CH];
    logic [2:0]       ctrl_d   [N_CH];
    logic [CNT_W-1:0] period_q [N_CH];
    logic [CNT_W-1:0] period_d [N_CH];
    logic [CNT_W-1:0] count_q  [N_CH];
    logic [CNT_W-1:0] count_d  [N_CH];
    logic             pend_q   [N_CH];
    logic             pend_d   [N_CH];
    logic             ovr_q    [N_CH];
    logic             ovr_d    [N_CH];

    logic [31:0]      irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ack_q, ack_d;

    // Bits of eoi/wdata/addr beyond the bank's needs are deliberately ignored.
    logic             unused_s;
    assign unused_s = ^{eoi_i, bus.wdata_i, bus.addr_i};

    assign ch_s  = bus.addr_i[CH_W+1:2];
    assign reg_s = bus.addr_i[1:0];

    // Per-channel counter, control and pending/overrun next-state logic.
    always_comb begin
        irq_d = 32'h0000_0000;
        for (int c = 0; c < N_CH; c++) begin
            logic wr_s, live_s, term_s, st_wr_s, clr_s;
            wr_s    = bus.req_i & bus.we_i & (ch_s == CH_W'(c));
            live_s  = ctrl_q[c][0] & (period_q[c] != CNT_ZERO);
            term_s  = live_s & (count_q[c] == (period_q[c] - CNT_ONE));
            st_wr_s = wr_s & (reg_s == 2'd3);
            // eoi and W1C share the clear path; a same-cycle fire still wins.
            clr_s   = eoi_i[IRQ_BASE+c] | (st_wr_s & bus.wdata_i[0]);

            pend_d[c] = term_s ? 1'b1 : (clr_s ? 1'b0 : pend_q[c]);
            ovr_d[c]  = (term_s & pend_q[c] & ~clr_s) ? 1'b1 :
                        ((st_wr_s & bus.wdata_i[1]) ? 1'b0 : ovr_q[c]);

            // CPU write to CTRL overrides the one-shot self-disable.
            if (wr_s && (reg_s == 2'd0)) begin
                ctrl_d[c] = bus.wdata_i[2:0];
            end else if (term_s && ctrl_q[c][1]) begin
                ctrl_d[c] = {ctrl_q[c][2:1], 1'b0};
            end else begin
                ctrl_d[c] = ctrl_q[c];
            end

            // PERIOD write restarts the count regardless of the counter state.
            if (wr_s && (reg_s == 2'd1)) begin
                period_d[c] = bus.wdata_i[CNT_W-1:0];
                count_d[c]  = CNT_ZERO;
            end else if (!live_s || term_s) begin
                period_d[c] = period_q[c];
                count_d[c]  = CNT_ZERO;
            end else begin
                period_d[c] = period_q[c];
                count_d[c]  = count_q[c] + CNT_ONE;
            end

            irq_d[IRQ_BASE+c] = pend_q[c] & ctrl_q[c][2];
        end
    end

    // Read mux: data is taken from the register state at the request edge.
    always_comb begin
        ack_d   = bus.req_i;
        rdata_d = rdata_q;
        if (bus.req_i && !bus.we_i) begin
            rdata_d = 32'h0000_0000;
            for (int c = 0; c < N_CH; c++) begin
                if (ch_s == CH_W'(c)) begin
                    case (reg_s)
                        2'd0:    rdata_d = {29'h0, ctrl_q[c]};
                        2'd1:    rdata_d = 32'(period_q[c]);
                        2'd2:    rdata_d = 32'(count_q[c]);
                        2'd3:    rdata_d = {30'h0, ovr_q[c], pend_q[c]};
                        default: rdata_d = 32'h0000_0000;
                    endcase
                end else begin
                    rdata_d = rdata_d;
                end
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < N_CH; c++) begin
                ctrl_q[c]   <= 3'b000;
                period_q[c] <= CNT_ZERO;
                count_q[c]  <= CNT_ZERO;
                pend_q[c]   <= 1'b0;
                ovr_q[c]    <= 1'b0;
            end
            irq_q   <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            ack_q   <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                ctrl_q[c]   <= ctrl_d[c];
                period_q[c] <= period_d[c];
                count_q[c]  <= count_d[c];
                pend_q[c]   <= pend_d[c];
                ovr_q[c]    <= ovr_d[c];
            end
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    assign irq_o       = irq_q;
    assign bus.rdata_o = rdata_q;
    assign bus.ack_o   = ack_q;
endmodule
